// File: rtl/hiscore_arb_pkg.sv
// Shared types for the hiscore work-RAM arbiter: FSM states and port-owner encoding.
package hiscore_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VBL,
        SETTLE,
        GRANT,
        DRAIN,
        RELEASE,
        ABORT
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_HS  = 1'b1;

endpackage

// File: rtl/arb_wait_timer.sv
// Loadable saturating up-counter; done flags when the count sits at LIMIT.
module arb_wait_timer #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !done) begin
            count <= count + W'(1);
        end
    end

    assign done = (count == LIM);

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Shares the game work-RAM port between the Z80 and the hiscore engine,
// pausing the CPU and waiting for vblank plus a settle period before granting.
module hiscore_ram_arbiter
    import hiscore_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int SETTLE_CYC  = 8,
    parameter int VBL_TIMEOUT = 1048575
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vblank,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    output logic          hs_grant,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_rvalid,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          pause_req,
    output logic          busy,
    output logic          cpu_collision
);

    // IDLE: CPU owns port | WAIT_VBL: paused, awaiting vblank | SETTLE: let CPU bus cycle finish
    // GRANT: hiscore owns port | DRAIN: last read returns | RELEASE: hand back | ABORT: cancelled
    localparam int TW = $clog2(VBL_TIMEOUT + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    arb_state_t state;
    logic       sel;
    logic       vbl_timeout;
    logic       settle_done;

    arb_wait_timer #(.W(TW), .LIMIT(VBL_TIMEOUT)) u_vbl_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != WAIT_VBL),
        .en      (state == WAIT_VBL),
        .done    (vbl_timeout)
    );

    arb_wait_timer #(.W(SW), .LIMIT(SETTLE_CYC - 1)) u_settle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != SETTLE),
        .en      (state == SETTLE),
        .done    (settle_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sel           <= OWN_CPU;
            hs_grant      <= 1'b0;
            pause_req     <= 1'b0;
            hs_rvalid     <= 1'b0;
            cpu_collision <= 1'b0;
        end else begin
            hs_rvalid <= (state == GRANT) && !hs_we;
            if (state == GRANT && cpu_we) cpu_collision <= 1'b1;
            case (state)
                IDLE: if (hs_req) begin
                    state     <= WAIT_VBL;
                    pause_req <= 1'b1;
                end
                WAIT_VBL: begin
                    if (!hs_req) state <= ABORT;
                    else if (vblank || vbl_timeout) state <= SETTLE;
                end
                SETTLE: begin
                    if (!hs_req) begin
                        state <= ABORT;
                    end else if (settle_done) begin
                        state    <= GRANT;
                        sel      <= OWN_HS;
                        hs_grant <= 1'b1;
                    end
                end
                GRANT: if (!hs_req) begin
                    state    <= DRAIN;
                    hs_grant <= 1'b0;
                end
                DRAIN: state <= RELEASE;
                RELEASE: begin
                    state     <= IDLE;
                    sel       <= OWN_CPU;
                    pause_req <= 1'b0;
                end
                ABORT: begin
                    state     <= IDLE;
                    pause_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sel stays HS through DRAIN/RELEASE so the engine's last read completes
    assign ram_addr  = (sel == OWN_HS) ? hs_addr  : cpu_addr;
    assign ram_wdata = (sel == OWN_HS) ? hs_wdata : cpu_wdata;
    assign ram_we    = (sel == OWN_HS) ? (hs_we && hs_grant && state == GRANT) : cpu_we;
    assign cpu_rdata = ram_rdata;
    assign hs_rdata  = ram_rdata;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: table of idle-passthrough vectors, directed grant/release/timeout
// sequences, and randomized transactions checked against a timeline model and a shadow RAM.
module tb_hiscore_ram_arbiter;

    localparam int SETTLE = 8;

    logic        clk = 1'b0, reset_n = 1'b0, vblank = 1'b0, hs_req = 1'b0;
    logic        hs_we = 1'b0, cpu_we = 1'b0;
    logic [15:0] hs_addr = '0, cpu_addr = '0;
    logic [7:0]  hs_wdata = '0, cpu_wdata = '0;
    logic [7:0]  ram_rdata;

    logic        hs_grant, hs_rvalid, ram_we, pause_req, busy, cpu_collision;
    logic [7:0]  hs_rdata, cpu_rdata, ram_wdata;
    logic [15:0] ram_addr;
    logic        hs_grant_t, hs_rvalid_t, ram_we_t, pause_t, busy_t, coll_t;
    logic [7:0]  hs_rdata_t, cpu_rdata_t, ram_wdata_t;
    logic [15:0] ram_addr_t;

    int checks = 0;
    int errors = 0;
    bit coll;
    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];

    hiscore_ram_arbiter #(.AW(16), .DW(8), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .hs_req(hs_req),
        .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_grant(hs_grant),
        .hs_rdata(hs_rdata), .hs_rvalid(hs_rvalid), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .pause_req(pause_req), .busy(busy),
        .cpu_collision(cpu_collision)
    );

    hiscore_ram_arbiter #(.AW(16), .DW(8), .SETTLE_CYC(SETTLE), .VBL_TIMEOUT(50)) dut_t (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .hs_req(hs_req),
        .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_grant(hs_grant_t),
        .hs_rdata(hs_rdata_t), .hs_rvalid(hs_rvalid_t), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata_t),
        .ram_addr(ram_addr_t), .ram_wdata(ram_wdata_t), .ram_we(ram_we_t),
        .ram_rdata(ram_rdata), .pause_req(pause_t), .busy(busy_t),
        .cpu_collision(coll_t)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // work RAM with 1-cycle read latency, preloaded while reset is held
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; hs_req = 1'b0; vblank = 1'b0; hs_we = 1'b0; cpu_we = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 65536; i++) shadow[i] = init_val(16'(i));
        coll = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic rand_cpu();
        cpu_addr  = 16'($urandom_range(0, 32767));
        cpu_wdata = 8'($urandom);
        cpu_we    = 1'($urandom_range(0, 1));
    endtask

    // hs_req drop while granted (a read on the drop cycle), then DRAIN, RELEASE, back to IDLE
    task automatic release_seq(input bit re);
        logic [15:0] a;
        a = 16'h8000 + 16'($urandom_range(0, 15));
        hs_req = 1'b0; hs_we = 1'b0; hs_addr = a;
        rand_cpu();
        #1;
        chk("drop_addr", ram_addr, a);
        if (cpu_we) coll = 1'b1;
        tick();
        chk("drain_grant", hs_grant, 0);
        chk("drain_rvalid", hs_rvalid, 1);
        chk("drain_rdata", hs_rdata, shadow[a]);
        chk("drain_pause", pause_req, 1);
        hs_we = 1'b1; hs_req = re; cpu_we = 1'b1;
        #1;
        chk("drain_we", ram_we, 0);
        chk("drain_sel", ram_addr, a);
        tick();
        chk("release_pause", pause_req, 1);
        chk("release_rvalid", hs_rvalid, 0);
        #1;
        chk("release_we", ram_we, 0);
        tick();
        chk("idle_pause", pause_req, 0);
        chk("idle_busy", busy, 0);
        chk("idle_grant", hs_grant, 0);
        chk("idle_coll", cpu_collision, coll);
        hs_we = 1'b0;
        rand_cpu();
        #1;
        chk("idle_sel", ram_addr, cpu_addr);
        chk("idle_we", ram_we, cpu_we);
    endtask

    // Model: vblank seen from edge d on; WAIT_VBL exits at edge max(d,1), grant at that + SETTLE.
    // Dropping hs_req at any edge up to the grant edge aborts with no grant.
    task automatic run_txn(input int d, input bit ab, input bit re, input int nops);
        int g, a;
        logic [15:0] ad;
        logic [7:0] dt;
        logic w;
        g = ((d > 1) ? d : 1) + SETTLE;
        a = $urandom_range(1, g);
        for (int k = 0; k <= g; k++) begin
            vblank = (k >= d);
            hs_req = !(ab && k >= a);
            rand_cpu();
            #1;
            chk("pre_addr", ram_addr, cpu_addr);
            chk("pre_we", ram_we, cpu_we);
            tick();
            chk("pre_grant", hs_grant, (!ab && k == g));
            if (ab && k >= a) begin
                tick();
                chk("abort_pause", pause_req, 0);
                chk("abort_busy", busy, 0);
                chk("abort_grant", hs_grant, 0);
                chk("abort_coll", cpu_collision, coll);
                vblank = 1'b0;
                return;
            end
            chk("pre_pause", pause_req, 1);
        end
        vblank = 1'b0;
        chk("grant_busy", busy, 1);
        for (int i = 0; i < nops; i++) begin
            w  = 1'($urandom_range(0, 1));
            ad = 16'h8000 + 16'($urandom_range(0, 15));
            dt = 8'($urandom);
            hs_we = w; hs_addr = ad; hs_wdata = dt;
            rand_cpu();
            #1;
            chk("g_addr", ram_addr, ad);
            chk("g_we", ram_we, w);
            chk("g_wdata", ram_wdata, dt);
            if (cpu_we) coll = 1'b1;
            tick();
            chk("g_rvalid", hs_rvalid, !w);
            if (w) shadow[ad] = dt;
            else chk("g_rdata", hs_rdata, shadow[ad]);
            chk("g_coll", cpu_collision, coll);
        end
        release_seq(re);
    endtask

    typedef struct {
        logic [15:0] ca;
        logic [7:0]  cw;
        logic        cwe;
        logic [15:0] ha;
        logic        hwe;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wdata;
        logic        exp_we;
    } vec_t;

    initial begin
        vec_t tbl [4];
        tbl[0] = '{16'h8123, 8'h3C, 1'b1, 16'h1111, 1'b0, 16'h8123, 8'h3C, 1'b1};
        tbl[1] = '{16'h0000, 8'hFF, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 8'hFF, 1'b0};
        tbl[2] = '{16'hFFFF, 8'h00, 1'b1, 16'h8040, 1'b1, 16'hFFFF, 8'h00, 1'b1};
        tbl[3] = '{16'h4A5B, 8'h96, 1'b0, 16'h4A5A, 1'b0, 16'h4A5B, 8'h96, 1'b0};

        do_reset();
        chk("rst_pause", pause_req, 0);
        chk("rst_grant", hs_grant, 0);
        chk("rst_rvalid", hs_rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_coll", cpu_collision, 0);
        cpu_addr = 16'h2222; hs_addr = 16'h9999;
        #1;
        chk("rst_sel", ram_addr, 16'h2222);

        foreach (tbl[i]) begin
            cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cw; cpu_we = tbl[i].cwe;
            hs_addr = tbl[i].ha; hs_we = tbl[i].hwe; hs_wdata = 8'h77;
            #1;
            chk("tbl_addr", ram_addr, tbl[i].exp_addr);
            chk("tbl_wdata", ram_wdata, tbl[i].exp_wdata);
            chk("tbl_we", ram_we, tbl[i].exp_we);
            tick();
            chk("tbl_rdata", cpu_rdata, init_val(tbl[i].ca));
            chk("tbl_pause", pause_req, 0);
            chk("tbl_busy", busy, 0);
        end

        do_reset();
        hs_req = 1'b1;
        tick();
        chk("ng_pause1", pause_req, 1);
        chk("ng_busy1", busy, 1);
        repeat (99) tick();
        chk("ng_wait_grant", hs_grant, 0);
        vblank = 1'b1;
        repeat (8) tick();
        chk("ng_vbl8_grant", hs_grant, 0);
        tick();
        chk("ng_vbl9_grant", hs_grant, 1);
        vblank = 1'b0;
        hs_addr = 16'h8040; hs_we = 1'b0;
        #1;
        chk("ng_rd_addr", ram_addr, 16'h8040);
        tick();
        chk("ng_rvalid", hs_rvalid, 1);
        chk("ng_rdata", hs_rdata, shadow[16'h8040]);
        release_seq(1'b0);

        do_reset();
        hs_req = 1'b1;
        repeat (59) tick();
        chk("to_58_grant", hs_grant_t, 0);
        tick();
        chk("to_59_grant", hs_grant_t, 1);
        chk("to_pause", pause_t, 1);
        cpu_we = 1'b1; cpu_addr = 16'h1234; hs_addr = 16'h8001; hs_we = 1'b0;
        #1;
        chk("coll_we", ram_we_t, 0);
        chk("coll_addr", ram_addr_t, 16'h8001);
        tick();
        chk("coll_set", coll_t, 1);
        cpu_we = 1'b0;
        repeat (3) tick();
        chk("coll_sticky", coll_t, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", hs_grant_t, 0);
        chk("arst_pause", pause_t, 0);
        chk("arst_busy", busy_t, 0);
        chk("arst_coll", coll_t, 0);
        chk("arst_sel", ram_addr_t, 16'h1234);

        do_reset();
        for (int t = 0; t < 25; t++) begin
            run_txn($urandom_range(0, 15), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(1, 6));
            if (!hs_req) repeat (2) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
